// File: rtl/multi_debounce_pulse.sv
// N-channel debouncer with a per-channel one-shot pulse on qualifying debounced edges.
// Define DEB_SYNC_EN to put a 2-flop synchroniser in front of each input bit.
module multi_debounce_pulse #(
    parameter int   N            = 4,
    parameter int   DEB_CYCLES   = 100,
    parameter int   PULSE_CYCLES = 5,
    parameter int   EDGE_MODE    = 0,
    parameter int   RETRIGGER    = 0,
    parameter logic INIT_LEVEL   = 1'b0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] IN,
    input  logic [N-1:0] EN,
    output logic [N-1:0] LEVEL,
    output logic [N-1:0] OUT,
    output logic         ANY
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] PLS_MAX = PW'(PULSE_CYCLES - 1);

    logic [N-1:0]  s;
    logic [N-1:0]  level_q, level_d;
    logic [N-1:0]  out_q, out_d;
    logic [DW-1:0] deb_cnt_q [N];
    logic [DW-1:0] deb_cnt_d [N];
    logic [PW-1:0] pls_cnt_q [N];
    logic [PW-1:0] pls_cnt_d [N];
    logic [N-1:0]  rise, fall, fire;

`ifdef DEB_SYNC_EN
    logic [N-1:0] sync1_q, sync2_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= {N{INIT_LEVEL}};
            sync2_q <= {N{INIT_LEVEL}};
        end else begin
            sync1_q <= IN;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = IN;
`endif

    always_comb begin
        level_d   = level_q;
        out_d     = out_q;
        deb_cnt_d = deb_cnt_q;
        pls_cnt_d = pls_cnt_q;
        rise      = '0;
        fall      = '0;
        fire      = '0;
        for (int i = 0; i < N; i++) begin
            // Any return to the accepted level restarts the stability count
            if (s[i] == level_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_MAX) begin
                level_d[i]   = s[i];
                deb_cnt_d[i] = '0;
                rise[i]      = s[i];
                fall[i]      = ~s[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end

            fire[i] = EN[i] & (((EDGE_MODE == 0) & rise[i]) |
                               ((EDGE_MODE == 1) & fall[i]) |
                               ((EDGE_MODE == 2) & (rise[i] | fall[i])));

            if (fire[i] && (!out_q[i] || RETRIGGER != 0)) begin
                out_d[i]     = 1'b1;
                pls_cnt_d[i] = '0;
            end else if (out_q[i]) begin
                if (!EN[i] || pls_cnt_q[i] == PLS_MAX) begin
                    out_d[i]     = 1'b0;
                    pls_cnt_d[i] = '0;
                end else begin
                    pls_cnt_d[i] = pls_cnt_q[i] + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            level_q <= {N{INIT_LEVEL}};
            out_q   <= '0;
            for (int i = 0; i < N; i++) begin
                deb_cnt_q[i] <= '0;
                pls_cnt_q[i] <= '0;
            end
        end else begin
            level_q   <= level_d;
            out_q     <= out_d;
            deb_cnt_q <= deb_cnt_d;
            pls_cnt_q <= pls_cnt_d;
        end
    end

    assign LEVEL = level_q;
    assign OUT   = out_q;
    assign ANY   = |out_q;

endmodule
